// File: rtl/register_file_pkg.sv
// Shared types and helpers for the parametrised register file.
package register_file_pkg;

    // The block is either sweeping entries to zero or serving reads/writes.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    // Number of entries addressed by an addr_w-bit address.
    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One asynchronous read port: storage mux with clear, zero-register and
// write-bypass overrides applied in priority order.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = rf_depth(ADDR_W)
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_ena,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  mem [DEPTH],
    output logic [WIDTH-1:0]  rd_data
);

    // Clearing hides the (possibly stale or X) storage; x0 is hard zero; a
    // same-cycle write to the read address is forwarded ahead of storage.
    always_comb begin
        rd_data = mem[rd_addr];
        if (!ready) begin
            rd_data = '0;
        end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
        end else if ((BYPASS != 0) && wr_ena && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file with a clear sequencer instead of per-entry
// reset, optional hard-wired zero register and optional write bypass.
module register_file_param
    import register_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic                     wr_ena,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_drop,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data
);

    localparam int DEPTH = rf_depth(ADDR_W);

    rf_state_t         state;
    rf_state_t         state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] clr_ptr_next;
    logic              wr_commit;
    logic [WIDTH-1:0]  mem [DEPTH];

    assign ready     = (state == RF_READY);
    assign wr_commit = ready && wr_ena && !((ZERO_REG != 0) && (wr_addr == '0));

    // State and sweep pointer register; reset restarts the sweep at entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Sweep advances one entry per cycle; a clear request only counts when idle.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            RF_CLEAR: begin
                clr_ptr_next = clr_ptr + ADDR_W'(1);
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state_next = RF_READY;
                end
            end
            RF_READY: begin
                if (clr_req) begin
                    state_next   = RF_CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = RF_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    // Storage: zeroed by the sweep, otherwise written by committed writes only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_commit) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // One-cycle flag for every write that arrived while the sweep was running.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= (state == RF_CLEAR) && wr_ena;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .WIDTH    (WIDTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .ready   (ready),
            .rd_addr (rd_addr[k*ADDR_W +: ADDR_W]),
            .wr_ena  (wr_ena),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .mem     (mem),
            .rd_data (rd_data[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a default build (32x32, 2 ports, zero reg,
// bypass) and a wide build (64x8, 4 ports, no zero reg, no bypass), both
// checked every cycle against a behavioural model.
module tb_register_file_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default build stimulus and outputs
    logic        clr_a, we_a, ready_a, drop_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic [4:0]  ra_a [2];
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    assign rd_addr_a = {ra_a[1], ra_a[0]};

    // Wide build stimulus and outputs
    logic         clr_b, we_b, ready_b, drop_b;
    logic [2:0]   wa_b;
    logic [63:0]  wd_b;
    logic [2:0]   ra_b [4];
    logic [11:0]  rd_addr_b;
    logic [255:0] rd_data_b;
    assign rd_addr_b = {ra_b[3], ra_b[2], ra_b[1], ra_b[0]};

    register_file_param #(
        .WIDTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_a), .ready(ready_a),
        .wr_ena(we_a), .wr_addr(wa_a), .wr_data(wd_a), .wr_drop(drop_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    register_file_param #(
        .WIDTH(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_b), .ready(ready_b),
        .wr_ena(we_b), .wr_addr(wa_b), .wr_data(wd_b), .wr_drop(drop_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    // Reference model: contents as they will read once idle, plus the number
    // of cycles of sweep still to go (0 = ready).
    logic [31:0] mem_a [32];
    logic [63:0] mem_b [8];
    int          busy_a, busy_b;
    logic        drop_exp_a, drop_exp_b;

    int   total, passed;
    bit   checking;
    logic seen_ready_a, seen_ready_b;
    int   cnt_a, cnt_b;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] expReadA(input logic [4:0] a);
        if (busy_a > 0) return '0;
        if (a == 5'd0) return '0;
        if (we_a && a == wa_a) return wd_a;
        return mem_a[a];
    endfunction

    function automatic logic [63:0] expReadB(input logic [2:0] a);
        if (busy_b > 0) return '0;
        return mem_b[a];
    endfunction

    task automatic updateModel();
        if (rst) begin
            busy_a = 32; drop_exp_a = 1'b0;
            foreach (mem_a[i]) mem_a[i] = '0;
            busy_b = 8;  drop_exp_b = 1'b0;
            foreach (mem_b[i]) mem_b[i] = '0;
        end else begin
            if (busy_a > 0) begin
                busy_a--; drop_exp_a = we_a;
            end else begin
                drop_exp_a = 1'b0;
                if (we_a && wa_a != 5'd0) mem_a[wa_a] = wd_a;
                if (clr_a) begin
                    busy_a = 32;
                    foreach (mem_a[i]) mem_a[i] = '0;
                end
            end
            if (busy_b > 0) begin
                busy_b--; drop_exp_b = we_b;
            end else begin
                drop_exp_b = 1'b0;
                if (we_b) mem_b[wa_b] = wd_b;
                if (clr_b) begin
                    busy_b = 8;
                    foreach (mem_b[i]) mem_b[i] = '0;
                end
            end
        end
    endtask

    // One clock cycle with the inputs currently driven: check at the falling
    // edge, advance the model at the rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        seen_ready_a = ready_a;
        seen_ready_b = ready_b;
        if (checking) begin
            checkOutput("a_ready", 64'(ready_a), 64'(busy_a == 0));
            checkOutput("a_drop", 64'(drop_a), 64'(drop_exp_a));
            for (int k = 0; k < 2; k++)
                checkOutput($sformatf("a_rd%0d@%0d", k, ra_a[k]),
                            64'(rd_data_a[k*32 +: 32]), 64'(expReadA(ra_a[k])));
            checkOutput("b_ready", 64'(ready_b), 64'(busy_b == 0));
            checkOutput("b_drop", 64'(drop_b), 64'(drop_exp_b));
            for (int k = 0; k < 4; k++)
                checkOutput($sformatf("b_rd%0d@%0d", k, ra_b[k]),
                            rd_data_b[k*64 +: 64], expReadB(ra_b[k]));
        end
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic setIdle();
        clr_a = 1'b0; we_a = 1'b0; wa_a = '0; wd_a = '0;
        clr_b = 1'b0; we_b = 1'b0; wa_b = '0; wd_b = '0;
        foreach (ra_a[k]) ra_a[k] = '0;
        foreach (ra_b[k]) ra_b[k] = '0;
    endtask

    task automatic randomReads();
        foreach (ra_a[k]) ra_a[k] = 5'($urandom_range(0, 31));
        foreach (ra_b[k]) ra_b[k] = 3'($urandom_range(0, 7));
    endtask

    initial begin
        total = 0; passed = 0; checking = 0;
        busy_a = 32; busy_b = 8; drop_exp_a = 0; drop_exp_b = 0;
        setIdle();

        // Reset for two cycles, then measure the sweep length of both builds
        rst = 1'b1;
        applyStimulus();
        checking = 1;
        applyStimulus();
        rst = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 100; i++) begin
            randomReads();
            applyStimulus();
            if (!seen_ready_a) cnt_a++;
            if (!seen_ready_b) cnt_b++;
            if (seen_ready_a && seen_ready_b) break;
        end
        checkOutput("a_reset_sweep_len", 64'(cnt_a), 64'd32);
        checkOutput("b_reset_sweep_len", 64'(cnt_b), 64'd8);

        // Plain write then read on both ports
        setIdle();
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF; ra_a[0] = 5'd5; ra_a[1] = 5'd5;
        applyStimulus();
        we_a = 1'b0;
        #1;
        checkOutput("a_x5_p0", 64'(rd_data_a[31:0]), 64'h0000_0000_DEAD_BEEF);
        checkOutput("a_x5_p1", 64'(rd_data_a[63:32]), 64'h0000_0000_DEAD_BEEF);
        applyStimulus();

        // Write to x0 is ignored silently
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'h1234; ra_a[0] = 5'd0; ra_a[1] = 5'd0;
        applyStimulus();
        we_a = 1'b0;
        #1;
        checkOutput("a_x0_zero", 64'(rd_data_a[31:0]), 64'd0);
        checkOutput("a_x0_no_drop", 64'(drop_a), 64'd0);
        applyStimulus();

        // Same-cycle forwarding (default build) vs. old value (wide build)
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1111_1111;
        we_b = 1'b1; wa_b = 3'd7; wd_b = 64'h1111_1111_1111_1111;
        applyStimulus();
        wd_a = 32'hA5A5A5A5; ra_a[1] = 5'd7;
        wd_b = 64'hA5A5_A5A5_A5A5_A5A5; ra_b[1] = 3'd7;
        #1;
        checkOutput("a_bypass_p1", 64'(rd_data_a[63:32]), 64'h0000_0000_A5A5_A5A5);
        checkOutput("b_no_bypass_p1", rd_data_b[127:64], 64'h1111_1111_1111_1111);
        applyStimulus();
        setIdle();

        // Fill with index values, then a runtime clear with a redundant request
        // and a dropped write mid-sweep
        for (int i = 1; i < 32; i++) begin
            we_a = 1'b1; wa_a = 5'(i); wd_a = 32'(i);
            we_b = (i < 8); wa_b = 3'(i); wd_b = 64'(i) << 32 | 64'(i);
            randomReads();
            applyStimulus();
        end
        setIdle();
        clr_a = 1'b1; clr_b = 1'b1;
        applyStimulus();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 100; i++) begin
            clr_a = (i == 10);
            clr_b = (i == 3);
            we_a = (i == 5); wa_a = 5'd3; wd_a = 32'h55;
            if (i == 6) checkOutput("a_drop_pulse", 64'(drop_a), 64'd1);
            randomReads();
            applyStimulus();
            if (!seen_ready_a) cnt_a++;
            if (!seen_ready_b) cnt_b++;
            if (seen_ready_a && seen_ready_b) break;
        end
        checkOutput("a_clr_sweep_len", 64'(cnt_a), 64'd32);
        checkOutput("b_clr_sweep_len", 64'(cnt_b), 64'd8);
        setIdle();
        for (int i = 0; i < 32; i++) begin
            ra_a[0] = 5'(i); ra_a[1] = 5'(31 - i);
            foreach (ra_b[k]) ra_b[k] = 3'(i + k);
            applyStimulus();
        end
        ra_a[0] = 5'd3;
        #1;
        checkOutput("a_x3_cleared", 64'(rd_data_a[31:0]), 64'd0);

        // Wide build: entry 0 is an ordinary register
        we_b = 1'b1; wa_b = 3'd0; wd_b = 64'hFFFF_FFFF_0000_0001;
        foreach (ra_b[k]) ra_b[k] = 3'd0;
        applyStimulus();
        we_b = 1'b0;
        #1;
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("b_e0_p%0d", k), rd_data_b[k*64 +: 64], 64'hFFFF_FFFF_0000_0001);
        applyStimulus();

        // Random traffic including occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            clr_a = ($urandom_range(0, 59) == 0);
            clr_b = ($urandom_range(0, 59) == 0);
            we_a  = 1'($urandom_range(0, 1));
            wa_a  = 5'($urandom_range(0, 31));
            wd_a  = $urandom;
            we_b  = 1'($urandom_range(0, 1));
            wa_b  = 3'($urandom_range(0, 7));
            wd_b  = {$urandom, $urandom};
            randomReads();
            if ($urandom_range(0, 3) == 0) ra_a[1] = wa_a;
            if ($urandom_range(0, 3) == 0) ra_b[2] = wa_b;
            applyStimulus();
        end
        rst = 1'b0;
        setIdle();
        applyStimulus();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
